// File: rtl/rv32imc_types.sv
// Shared RV32/RV64 load-path types: load funct3 encodings and completion-queue entry layout.
package rv32imc_types;

  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_e;

  // Data is sized for the widest core; narrower builds use the low XLEN bits.
  typedef struct packed {
    logic                is_load;
    logic [2:0]          funct3;
    logic [2:0]          offset;
    logic [4:0]          rd;
    logic                done;
    logic [XLEN_MAX-1:0] data;
  } wb_entry_t;

  function automatic logic funct3_legal(input logic [2:0] f3, input int unsigned xlen);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      F3_LD, F3_LWU:                       ok = (xlen == 32'd64);
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wb_load_format.sv
// Load data formatter: aligns the offset to the access size, selects the lane and extends it.
module wb_load_format
  import rv32imc_types::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned OFFW = $clog2(XLEN / 8)
) (
  input  logic [2:0]      funct3_i,
  input  logic [OFFW-1:0] offset_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [OFFW-1:0] align_s;
  logic [XLEN-1:0] shifted_s;

  // Misaligned offsets are silently rounded down to the access size.
  always_comb begin
    align_s = offset_i;
    case (funct3_i)
      F3_LB, F3_LBU:  align_s = offset_i;
      F3_LH, F3_LHU:  align_s = offset_i & ~OFFW'(2'd1);
      F3_LW, F3_LWU:  align_s = offset_i & ~OFFW'(2'd3);
      default:        align_s = '0;
    endcase
  end

  assign shifted_s = rdata_i >> {align_s, 3'b000};

  always_comb begin
    data_o = '0;
    if (funct3_legal(funct3_i, XLEN)) begin
      case (funct3_i)
        F3_LB:   data_o = XLEN'($signed(shifted_s[7:0]));
        F3_LBU:  data_o = XLEN'(shifted_s[7:0]);
        F3_LH:   data_o = XLEN'($signed(shifted_s[15:0]));
        F3_LHU:  data_o = XLEN'(shifted_s[15:0]);
        F3_LW:   data_o = XLEN'($signed(shifted_s[31:0]));
        F3_LWU:  data_o = XLEN'(shifted_s[31:0]);
        F3_LD:   data_o = shifted_s;
        default: data_o = '0;
      endcase
    end else begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/wb_load_unit_chk.sv
// Checker for the writeback stage: a retiring load must carry an encoding this XLEN can execute.
module wb_load_unit_chk
  import rv32imc_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  input logic       retire_i,
  input logic       is_load_i,
  input logic [2:0] funct3_i
);

  a_legal_funct3: assert property (@(posedge clk) disable iff (rst)
    (retire_i && is_load_i) |-> funct3_legal(funct3_i, XLEN));

endmodule

// File: rtl/wb_load_unit.sv
// Writeback stage for the dmem return path: in-order completion queue of DEPTH outstanding
// requests, response capture, load formatting and a stallable writeback register.
module wb_load_unit
  import rv32imc_types::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned OFFW  = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_load,
  input  logic [2:0]      req_funct3,
  input  logic [OFFW-1:0] req_offset,
  input  logic [4:0]      req_rd,
  input  logic            dmem_resp,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            wb_stall,
  output logic            dmem_stall,
  output logic            o_valid,
  output logic            o_regf_we,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_write_data,
  output logic            o_resp_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t       q_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q, fill_q;
  logic [CW-1:0]   count_q, count_d, pend_q, pend_d;
  logic            wb_valid_q, wb_we_q, resp_err_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  wb_entry_t       head_s;
  logic            fill_s, bypass_s, head_rdy_s, retire_s, alloc_s;
  logic [XLEN-1:0] raw_s, fmt_s;
  logic            unused_s;

  // pend_q counts allocated entries still waiting for their response; fill_q is the oldest.
  assign head_s     = q_q[head_q];
  assign fill_s     = dmem_resp & (pend_q != '0);
  assign bypass_s   = fill_s & (fill_q == head_q);
  assign head_rdy_s = (count_q != '0) & (head_s.done | bypass_s);
  assign retire_s   = ~wb_stall & head_rdy_s;
  assign req_ready  = (count_q < CW'(DEPTH)) | retire_s;
  assign dmem_stall = ~req_ready;
  assign alloc_s    = req_valid & req_ready;
  assign raw_s      = bypass_s ? dmem_rdata : head_s.data[XLEN-1:0];
  assign count_d    = count_q + CW'(alloc_s) - CW'(retire_s);
  assign pend_d     = pend_q + CW'(alloc_s) - CW'(fill_s);
  assign unused_s   = ^{head_s.data, head_s.offset};

  wb_load_format #(.XLEN(XLEN)) u_fmt (
    .funct3_i (head_s.funct3),
    .offset_i (head_s.offset[OFFW-1:0]),
    .rdata_i  (raw_s),
    .data_o   (fmt_s)
  );

  // Allocation is written after the fill so a full-and-retiring slot reuse starts not-done.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i].done <= 1'b0;
    end else begin
      if (fill_s) begin
        q_q[fill_q].done <= 1'b1;
        q_q[fill_q].data <= XLEN_MAX'(dmem_rdata);
        fill_q           <= fill_q + PW'(1);
      end
      if (alloc_s) begin
        q_q[tail_q] <= '{is_load: req_is_load, funct3: req_funct3, offset: 3'(req_offset),
                         rd: req_rd, done: 1'b0, data: '0};
        tail_q      <= tail_q + PW'(1);
      end
      if (retire_s) head_q <= head_q + PW'(1);
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  // Writeback register; the error pulse is not subject to the stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= dmem_resp & (pend_q == '0);
      if (!wb_stall) begin
        if (retire_s) begin
          wb_valid_q <= 1'b1;
          wb_we_q    <= head_s.is_load & (head_s.rd != 5'd0);
          wb_rd_q    <= head_s.rd;
          wb_data_q  <= head_s.is_load ? fmt_s : '0;
        end else begin
          wb_valid_q <= 1'b0;
          wb_we_q    <= 1'b0;
        end
      end
    end
  end

  assign o_valid      = wb_valid_q;
  assign o_regf_we    = wb_we_q;
  assign o_rd_addr    = wb_rd_q;
  assign o_write_data = wb_data_q;
  assign o_resp_err   = resp_err_q;

  wb_load_unit_chk #(.XLEN(XLEN)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .retire_i  (retire_s),
    .is_load_i (head_s.is_load),
    .funct3_i  (head_s.funct3)
  );

endmodule
